// File: rtl/cvxif_result_arbiter.sv
// cvxif_result_arbiter: merges FIFO-buffered exec completions and same-cycle immediate results onto CV-X-IF
// Queued completions always win over immediate results so completion order is preserved.
module cvxif_result_arbiter #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned Depth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   done_valid_i,
    input  logic [IdWidth-1:0]     done_id_i,
    input  logic [DataWidth-1:0]   done_data_i,
    input  logic                   imm_valid_i,
    input  logic [IdWidth-1:0]     imm_id_i,
    input  logic [DataWidth-1:0]   imm_data_i,
    input  logic                   imm_we_i,
    output logic                   imm_ready_o,
    output logic                   x_result_valid_o,
    output logic [IdWidth-1:0]     x_result_id_o,
    output logic [DataWidth-1:0]   x_result_data_o,
    output logic                   x_result_we_o,
    input  logic                   x_result_ready_i,
    output logic                   busy_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   overflow_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullLvl = Depth[AW:0];
    localparam logic [AW:0] BusyLvl = FullLvl - 1'b1;

    logic [AW-1:0]      head_q, tail_q;
    logic [AW:0]        count_q;
    logic               overflow_q, empty, full, pop, push;
    logic [IdWidth-1:0]   id_mem   [Depth];
    logic [DataWidth-1:0] data_mem [Depth];

    assign empty = count_q == '0;
    assign full  = count_q == FullLvl;
    assign pop   = !empty && x_result_ready_i;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = done_valid_i && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop) head_q <= head_q + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            if (done_valid_i && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[tail_q]   <= done_id_i;
            data_mem[tail_q] <= done_data_i;
        end
    end

    always_comb begin
        x_result_valid_o = !empty || imm_valid_i;
        x_result_id_o    = !empty ? id_mem[head_q] : imm_valid_i ? imm_id_i : '0;
        x_result_data_o  = !empty ? data_mem[head_q] : imm_valid_i ? imm_data_i : '0;
        x_result_we_o    = !empty ? 1'b1 : imm_valid_i && imm_we_i;
        imm_ready_o      = imm_valid_i && empty && x_result_ready_i;
        busy_o           = count_q >= BusyLvl;
        count_o          = count_q;
        overflow_o       = overflow_q;
    end
endmodule

// File: tb/tb_cvxif_result_arbiter.sv
// tb_cvxif_result_arbiter: directed and random stimulus checked against a queue-based result model
module tb_cvxif_result_arbiter;
    localparam int DW = 64, IW = 4, D = 4;

    logic          clk_i = 1'b0, rst_ni;
    logic          done_valid_i, imm_valid_i, imm_we_i, x_result_ready_i;
    logic [IW-1:0] done_id_i, imm_id_i;
    logic [DW-1:0] done_data_i, imm_data_i;
    logic          imm_ready_o, x_result_valid_o, x_result_we_o, busy_o, overflow_o;
    logic [IW-1:0] x_result_id_o;
    logic [DW-1:0] x_result_data_o;
    logic [2:0]    count_o;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   ovf;
    int   total, bad;

    always #5 clk_i = ~clk_i;

    cvxif_result_arbiter #(.DataWidth(DW), .IdWidth(IW), .Depth(D)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .done_valid_i(done_valid_i), .done_id_i(done_id_i), .done_data_i(done_data_i),
        .imm_valid_i(imm_valid_i), .imm_id_i(imm_id_i), .imm_data_i(imm_data_i),
        .imm_we_i(imm_we_i), .imm_ready_o(imm_ready_o),
        .x_result_valid_o(x_result_valid_o), .x_result_id_o(x_result_id_o),
        .x_result_data_o(x_result_data_o), .x_result_we_o(x_result_we_o),
        .x_result_ready_i(x_result_ready_i), .busy_o(busy_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("valid", 64'(x_result_valid_o), 64'(n > 0 || imm_valid_i));
        chk("id", 64'(x_result_id_o), n > 0 ? 64'(q[0].id) : imm_valid_i ? 64'(imm_id_i) : 64'd0);
        chk("data", x_result_data_o, n > 0 ? q[0].data : imm_valid_i ? imm_data_i : 64'd0);
        chk("we", 64'(x_result_we_o), n > 0 ? 64'd1 : 64'(imm_valid_i && imm_we_i));
        chk("imm_ready", 64'(imm_ready_o), 64'(imm_valid_i && n == 0 && x_result_ready_i));
        chk("busy", 64'(busy_o), 64'(n >= D - 1));
        chk("count", 64'(count_o), 64'(n));
        chk("overflow", 64'(overflow_o), 64'(ovf));
    endtask

    task automatic set(bit dv, int did, longint dd, bit iv, int iid, longint idat, bit iwe, bit rdy);
        done_valid_i     = dv;
        done_id_i        = IW'(did);
        done_data_i      = DW'(dd);
        imm_valid_i      = iv;
        imm_id_i         = IW'(iid);
        imm_data_i       = DW'(idat);
        imm_we_i         = iwe;
        x_result_ready_i = rdy;
    endtask

    // check outputs mid-low-phase, then apply the edge to the model with the same inputs
    task automatic tick();
        bit pop;
        #1 check_all();
        @(posedge clk_i);
        pop = q.size() > 0 && x_result_ready_i;
        if (done_valid_i && q.size() == D && !pop) ovf = 1'b1;
        else begin
            if (pop) void'(q.pop_front());
            if (done_valid_i) q.push_back('{id: done_id_i, data: done_data_i});
        end
        @(negedge clk_i);
    endtask

    task automatic areset();
        #2 rst_ni = 1'b0;
        #1 q.delete();
        ovf = 1'b0;
        check_all();
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ovf   = 1'b0;
        rst_ni = 1'b0;
        set(0, 0, 0, 0, 0, 0, 0, 0);
        #1 check_all();
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        set(1, 3, 'hAA, 0, 0, 0, 0, 1); tick();
        set(0, 0, 0, 0, 0, 0, 0, 1); tick(); tick();
        set(0, 0, 0, 1, 5, 'h55, 0, 1); tick();
        set(1, 1, 'h11, 0, 0, 0, 0, 1); tick();
        set(0, 0, 0, 1, 2, 'h22, 1, 1); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            set(1, 6 + i, 'h100 + i, 0, 0, 0, 0, 0); tick();
        end
        for (int i = 0; i < 5; i++) begin
            set(0, 0, 0, 0, 0, 0, 0, 1); tick();
        end
        areset();
        for (int i = 0; i < 4; i++) begin
            set(1, i, 'h200 + i, 0, 0, 0, 0, 0); tick();
        end
        set(1, 9, 'h209, 0, 0, 0, 0, 1); tick();
        set(0, 0, 0, 0, 0, 0, 0, 1); tick(); tick();
        areset();
        set(1, 12, 'h30C, 0, 0, 0, 0, 0); tick();
        set(1, 13, 'h30D, 0, 0, 0, 0, 0); tick();
        set(0, 0, 0, 0, 0, 0, 0, 1); tick(); tick(); tick();
        for (int i = 0; i < 400; i++) begin
            set($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                longint'({$urandom(), $urandom()}), $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 15)), longint'({$urandom(), $urandom()}),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
